fp16_div_iter: RTL

- Sequential IEEE-754 half-precision divider, quotient = dividend / divisor. It is the inverse-operation companion to the team's combinational FP16 multiplier.
- Uses restoring division on the 11-bit significands, one quotient bit per clock.
- Fixed latency, with a valid/ready input handshake and a one-cycle output strobe.
- Follows the multiplier's numeric conventions: truncation, no subnormals, zero flushing.

---
 rtl/fp16_div_iter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/fp16_div_iter.sv
// -----------------------------------------------------------------------------
// fp16_div_iter
//   Sequential IEEE-754 half-precision divider: quotient = dividend / divisor.
//   Restoring division on the 11-bit significands, one quotient bit per clock.
//   Numeric behaviour matches the team's combinational FP16 multiplier:
//   truncation (no rounding), no subnormal handling, results below the normal
//   range flush to +0. Exponent 5'h1F and subnormal inputs are not decoded;
//   every nonzero input is treated as a normal value with a hidden 1.
//
//   Timing: accept on edge E (in_valid && in_ready), 12 CALC edges E+1..E+12,
//   result registered on E+13, out_valid high for the single cycle after it.
//   One operation every 15 cycles at best. Latency is identical for special
//   cases: the iteration still runs and its result is simply overridden.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     operands present
//   in_ready     block idle, operands will be taken on the next edge
//   dividend     FP16 operand A
//   divisor      FP16 operand B
//   out_valid    one-cycle strobe, quotient valid
//   quotient     FP16 result, held until the next result
//   div_by_zero  divisor was +/-0 (qualified by out_valid, held with quotient)
//   overflow     exponent overflowed to Inf (qualified by out_valid)
// -----------------------------------------------------------------------------
module fp16_div_iter #(
  parameter int ITER = 12  // 1 integer + 11 fraction quotient bits; fixed
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        out_valid,
  output logic [15:0] quotient,
  output logic        div_by_zero,
  output logic        overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_NORM,
    S_DONE
  } state_t;

  state_t      r_state, w_next;

  // Operand / iteration registers
  logic        r_sign;
  logic [4:0]  r_ea, r_eb;
  logic [10:0] r_mb;
  logic [11:0] r_rem;
  logic [11:0] r_q;
  logic [3:0]  r_cnt;
  logic        r_bz;   // divisor is +/-0
  logic        r_az;   // dividend is +/-0

  // Output registers
  logic        r_ovalid;
  logic [15:0] r_quot;
  logic        r_dbz;
  logic        r_ovf;

  // Iteration datapath
  logic        w_ge;
  logic [10:0] w_diff;
  logic [11:0] w_rem_nxt;
  logic        w_last;

  // Normalisation / result select
  logic signed [6:0] w_exp;
  logic [9:0]  w_mant;
  logic [15:0] w_res;
  logic        w_res_dbz;
  logic        w_res_ovf;

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = r_ovalid;
  assign quotient    = r_quot;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

  // The partial remainder stays below 2*mB, so whenever rem >= mB the
  // difference is below mB (< 2^11) and the low 11 bits hold it exactly.
  // Likewise, when rem < mB bit 11 is already clear and the shift is lossless.
  assign w_ge      = (r_rem >= {1'b0, r_mb});
  assign w_diff    = r_rem[10:0] - r_mb;
  assign w_rem_nxt = w_ge ? {w_diff, 1'b0} : {r_rem[10:0], 1'b0};
  assign w_last    = (r_cnt == 4'(ITER - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_CALC;
      S_CALC:  if (w_last)   w_next = S_NORM;
      S_NORM:                w_next = S_DONE;
      S_DONE:                w_next = S_IDLE;
      default:               w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand capture and restoring iteration
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign <= 1'b0;
      r_ea   <= '0;
      r_eb   <= '0;
      r_mb   <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_bz   <= 1'b0;
      r_az   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign <= dividend[15] ^ divisor[15];
            r_ea   <= dividend[14:10];
            r_eb   <= divisor[14:10];
            r_mb   <= {1'b1, divisor[9:0]};
            r_rem  <= {1'b0, 1'b1, dividend[9:0]};
            r_q    <= '0;
            r_cnt  <= '0;
            r_bz   <= (divisor[14:0]  == 15'd0);
            r_az   <= (dividend[14:0] == 15'd0);
          end
        end
        S_CALC: begin
          r_q   <= {r_q[10:0], w_ge};
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Normalisation and special-case priority
  //   q = mA/mB lies in (0.5, 2): q[11] set means the quotient is >= 1.
  //   Exponent is evaluated in 7-bit signed so both overflow (>= 31) and
  //   underflow (<= 0) are visible before truncation to the 5-bit field.
  // ---------------------------------------------------------------------------
  assign w_exp  = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb})
                + (r_q[11] ? 7'sd15 : 7'sd14);
  assign w_mant = r_q[11] ? r_q[10:1] : r_q[9:0];

  always_comb begin
    w_res     = {r_sign, w_exp[4:0], w_mant};
    w_res_dbz = 1'b0;
    w_res_ovf = 1'b0;
    if (r_bz) begin
      w_res     = {r_sign, 5'h1F, 10'h000};
      w_res_dbz = 1'b1;
    end else if (r_az) begin
      w_res     = 16'h0000;
    end else if (w_exp >= 7'sd31) begin
      w_res     = {r_sign, 5'h1F, 10'h000};
      w_res_ovf = 1'b1;
    end else if (w_exp <= 7'sd0) begin
      w_res     = 16'h0000;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers: loaded only in NORM, so they hold between results.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovalid <= 1'b0;
      r_quot   <= 16'h0000;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_ovalid <= (r_state == S_NORM);
      if (r_state == S_NORM) begin
        r_quot <= w_res;
        r_dbz  <= w_res_dbz;
        r_ovf  <= w_res_ovf;
      end
    end
  end

endmodule
